instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC loaded at reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000, instruction word driven when no valid instruction.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  decode stage not accepting; output registers hold.
REQ-006 branch_taken  input  1  single-cycle redirect pulse from downstream.
REQ-007 branch_target  input  32  redirect address; bits [1:0] ignored, treated as 00.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_ack  input  1  memory returns data this cycle; valid only while imem_req=1.
REQ-011 imem_rdata  input  32  fetched word, valid with imem_ack.
REQ-012 instrWord  output  32  registered instruction to ControlPath.
REQ-013 instr_valid  output  1  instrWord holds a real instruction.
REQ-014 pc_plus4  output  32  address of instrWord + 4, registered with instrWord.

Function
REQ-015 FSM states: IDLE, FETCH, HOLD, DRAIN; encoding is free.
REQ-016 IDLE: imem_req=0; unconditional transition to FETCH on the first clk after reset release.
REQ-017 FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack.
REQ-018 FETCH, ack, no stall: instrWord<=imem_rdata, instr_valid<=1, pc_plus4<=pc+4, pc<=pc+4; remain in FETCH with imem_req=1.
REQ-019 FETCH, ack, stall: capture imem_rdata in a one-entry skid register, pc<=pc+4, go to HOLD; output registers unchanged.
REQ-020 FETCH, no ack, stall: output registers unchanged.
REQ-021 FETCH, no ack, no stall: instr_valid<=0, instrWord<=NOP_WORD.
REQ-022 HOLD: imem_req=0; when stall=0, skid moves to instrWord, instr_valid<=1, pc_plus4<=skid address+4; go to FETCH.
REQ-023 Throughput: one instruction per cycle when imem_ack is held high and stall=0; latency from ack to instrWord is 1 cycle.
REQ-024 branch_taken has priority over stall and ack: pc<=branch_target & ~3, instr_valid<=0, instrWord<=NOP_WORD on the next edge.
REQ-025 Branch in FETCH with ack in the same cycle: discard the returned data; next state is FETCH at the target.
REQ-026 Branch in FETCH without ack: go to DRAIN; keep imem_req=1 at the old address until ack, discard that data, then go to FETCH at the target.
REQ-027 Branch in HOLD: discard the skid entry and go to FETCH at the target.
REQ-028 Branch in DRAIN: update pc to the newest target; stay in DRAIN until ack.
REQ-029 In DRAIN, instr_valid=0 regardless of stall.
REQ-030 PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000; pc[1:0] always 00.

Reset
REQ-031 Asserting rst_n=0 takes effect immediately: state=IDLE, pc=RESET_PC, imem_req=0, instrWord=NOP_WORD, instr_valid=0, pc_plus4=0, skid cleared.
REQ-032 Reset during an outstanding request abandons it; any imem_ack in IDLE is ignored.

Structure
REQ-033 RESET_PC, NOP_WORD defaults and the FSM state encoding reside in a shared package used by the instr_fetch bench.
REQ-034 PC register with increment, redirect and hold selection shall be a sub-module named pc_reg; all other logic resides in instr_fetch.

Verification
REQ-035 Reset release, imem_ack tied 1, rdata=address -> imem_addr 0,4,8,...; instrWord equals prior imem_addr one cycle later; pc_plus4=instrWord+4.
REQ-036 Acked fetch of 0x8EAAAAAA with stall=1 for 3 cycles -> instrWord unchanged and imem_req=0 during stall; instrWord=0x8EAAAAAA one cycle after stall drops.
REQ-037 Outstanding request at 0x10 with ack delayed 4 cycles, branch_taken with target 0x43 -> DRAIN; data at 0x10 discarded; next imem_addr=0x40; instr_valid=0 until the 0x40 data arrives.
REQ-038 branch_taken, imem_ack and stall all asserted in one cycle -> data dropped, instr_valid=0, next imem_addr=target.
REQ-039 pc=0xFFFFFFFC, ack -> next imem_addr=0x00000000, pc_plus4=0x00000000.
REQ-040 rst_n=0 asserted mid-FETCH between clock edges -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
//   Shared definitions for the instruction fetch stage: default reset PC,
//   default NOP word, FSM state encoding and a word-alignment helper.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg
//   Program counter register with redirect / increment / hold selection.
//   Ports:
//     clk, rst_n   clock, async active-low reset (loads RESET_PC)
//     redirect     load word-aligned target (highest priority)
//     advance      pc <= pc + 4 (modulo 2^32)
//     target       redirect address, low two bits ignored
//     pc           current program counter, always word aligned
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = word_align(target);
    else if (advance) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= word_align(RESET_PC);
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction fetch stage: issues word fetches to instruction memory,
//   registers returned words toward decode, absorbs one decode stall via a
//   single-entry skid register and handles branch redirects, including
//   draining a request that is still outstanding when the branch arrives.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     stall                      decode not accepting; output registers hold
//     branch_taken/_target       one-cycle redirect (priority over all else)
//     imem_req/_addr             fetch request, held until imem_ack
//     imem_ack/_rdata            memory response
//     instrWord/instr_valid      registered instruction and its valid
//     pc_plus4                   address of instrWord + 4
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrWord,
  output logic        instr_valid,
  output logic [31:0] pc_plus4
);

  fetch_state_e state_d, state_q;
  logic [31:0]  instr_d, instr_q;
  logic         valid_d, valid_q;
  logic [31:0]  pp4_d, pp4_q;
  logic [31:0]  skid_data_d, skid_data_q;
  logic [31:0]  skid_addr_d, skid_addr_q;
  logic [31:0]  drain_addr_d, drain_addr_q;
  logic         advance;
  logic [31:0]  pc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .redirect (branch_taken),
    .advance  (advance),
    .target   (branch_target),
    .pc       (pc)
  );

  // In DRAIN the pc already holds the branch target, so the abandoned
  // request address is kept separately and presented until its ack.
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    pp4_d        = pp4_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;
    drain_addr_d = drain_addr_q;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (branch_taken) begin
          // Returned data (if any) belongs to the wrong path.
          state_d      = imem_ack ? S_FETCH : S_DRAIN;
          drain_addr_d = pc;
        end else if (imem_ack) begin
          advance = 1'b1;
          if (stall) begin
            skid_data_d = imem_rdata;
            skid_addr_d = pc;
            state_d     = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
            pp4_d   = pc + 32'd4;
          end
        end else if (!stall) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = skid_data_q;
          valid_d = 1'b1;
          pp4_d   = skid_addr_q + 32'd4;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        if (imem_ack) state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    if (branch_taken) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      instr_q      <= NOP_WORD;
      valid_q      <= 1'b0;
      pp4_q        <= 32'h0;
      skid_data_q  <= 32'h0;
      skid_addr_q  <= 32'h0;
      drain_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      pp4_q        <= pp4_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign instrWord   = instr_q;
  assign instr_valid = valid_q;
  assign pc_plus4    = pp4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
//   Scoreboard bench. The driver models the fetch stream at program level:
//   every useful acked word is pushed in order, a branch flushes everything
//   not yet accepted, and an ack to a request issued before a branch is
//   discarded. The monitor pops one entry per accepted instruction.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instrWord;
  logic        instr_valid;
  logic [31:0] pc_plus4;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instrWord    (instrWord),
    .instr_valid  (instr_valid),
    .pc_plus4     (pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pp4;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;
  bit          echo_addr = 0;

  // program-level model state
  logic [31:0] exp_pc;
  logic [31:0] drain_addr;
  bit          pend;      // next ack belongs to a pre-branch request
  bit          holding;   // a word is parked while decode stalls

  // what was driven during the cycle now ending
  bit          cur_req, cur_ack, cur_br, cur_stall;
  logic [31:0] cur_addr, cur_tgt, cur_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_cur();
    cur_req = 0; cur_ack = 0; cur_br = 0; cur_stall = 0;
    cur_addr = '0; cur_tgt = '0; cur_rdata = '0;
  endtask

  task automatic book();
    if (cur_br) begin
      q.delete();
      exp_pc  = cur_tgt & ~32'd3;
      holding = 0;
      if (cur_req && !cur_ack) begin
        pend       = 1;
        drain_addr = cur_addr;
      end else if (cur_req && cur_ack) begin
        pend = 0;
      end
    end else if (cur_req && cur_ack) begin
      if (pend) pend = 0;
      else begin
        q.push_back('{word: cur_rdata, pp4: cur_addr + 32'd4});
        exp_pc = cur_addr + 32'd4;
        if (cur_stall) holding = 1;
      end
    end else if (holding && !cur_stall) begin
      holding = 0;
    end
  endtask

  task automatic step(input bit a, input bit b, input logic [31:0] t,
                      input bit s, input logic [31:0] d);
    @(posedge clk);
    book();
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, !holding});
    if (imem_req) chk("imem_addr", imem_addr, pend ? drain_addr : exp_pc);
    imem_ack      = a & imem_req;
    branch_taken  = b;
    branch_target = t;
    stall         = s;
    imem_rdata    = echo_addr ? imem_addr : d;
    cur_req = imem_req; cur_addr = imem_addr; cur_ack = imem_ack;
    cur_br = b; cur_tgt = t; cur_stall = s; cur_rdata = imem_rdata;
  endtask

  // Reset asserted between edges; outputs must settle before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 0;
    imem_ack = 0; branch_taken = 0; stall = 0;
    #1;
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instrWord", instrWord, NOP_WORD_DEF);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC_DEF);
    q.delete();
    exp_pc = RESET_PC_DEF; pend = 0; holding = 0;
    clear_cur();
    repeat (2) @(posedge clk);
    #4 rst_n = 1;
  endtask

  // monitor: one pop per instruction decode accepts
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !done) begin
        if (instr_valid && !stall) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_instr actual=%h expected=none at %0t", instrWord, $time);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("instrWord", instrWord, e.word);
            chk("pc_plus4", pc_plus4, e.pp4);
          end
        end else if (!instr_valid) begin
          chk("nop_when_invalid", instrWord, NOP_WORD_DEF);
        end
      end
    end
  end

  initial begin
    exp_pc = RESET_PC_DEF; pend = 0; holding = 0; drain_addr = '0;
    clear_cur();
    do_reset();

    // streaming with ack tied high, data = address
    echo_addr = 1;
    repeat (12) step(1, 0, '0, 0, '0);
    echo_addr = 0;

    // ack with stall held three cycles
    step(1, 0, '0, 1, 32'h8EAA_AAAA);
    repeat (3) step(1, 0, '0, 1, 32'h1111_1111);
    repeat (3) step(1, 0, '0, 0, $urandom);

    // outstanding request at 0x10, branch to 0x43 while waiting
    step(1, 1, 32'h10, 0, $urandom);
    step(0, 0, '0, 0, '0);
    step(0, 1, 32'h43, 0, '0);
    repeat (3) step(0, 0, '0, $urandom_range(0, 1), '0);
    step(1, 0, '0, 0, 32'hDEAD_0010);
    step(0, 0, '0, 0, '0);
    repeat (3) step(1, 0, '0, 0, $urandom);

    // branch, ack and stall together
    step(1, 1, 32'h200, 1, 32'hBAD0_0000);
    repeat (3) step(1, 0, '0, 0, $urandom);

    // address wrap
    step(1, 1, 32'hFFFF_FFFE, 0, $urandom);
    repeat (4) step(1, 0, '0, 0, $urandom);

    do_reset();
    repeat (4) step(1, 0, '0, 0, $urandom);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 8,
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom,
           $urandom_range(0, 9) < 3,
           $urandom);
    end
    repeat (4) step(0, 0, '0, 0, '0);

    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
